// File: rtl/wb2core_pkg.sv
// wb2core_pkg: shared types and helpers for the pipelined Wishbone-to-core bridge
package wb2core_pkg;
   typedef enum logic {RUN, FLUSH} state_e;
   function automatic int cnt_width(input int max);
      return $clog2(max + 1);
   endfunction
endpackage

// File: rtl/core_if.sv
// core_if: Ibex-style memory port with request/grant and response-valid handshakes
interface core_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    req, we, gnt, rvalid, err;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata, rdata;
   modport master (output req, we, addr, be, wdata, input gnt, rvalid, err, rdata);
   modport slave (input req, we, addr, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/wb_if.sv
// wb_if: Wishbone pipelined bus; dat_m flows master->slave, dat_s slave->master
interface wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    cyc, stb, we, stall, ack, err;
   logic [ADDR_WIDTH-1:0]   adr;
   logic [DATA_WIDTH/8-1:0] sel;
   logic [DATA_WIDTH-1:0]   dat_m, dat_s;
   modport master (output cyc, stb, we, adr, sel, dat_m, input stall, ack, err, dat_s);
   modport slave (input cyc, stb, we, adr, sel, dat_m, output stall, ack, err, dat_s);
endinterface

// File: rtl/wb2core_pipe.sv
// wb2core_pipe: pipelined Wishbone slave to core memory port with bounded outstanding
// requests, optional registered response and flushing of responses owed to a dropped cycle
module wb2core_pipe
   import wb2core_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RSP_REG         = 1
) (
   input logic   clk_i,
   input logic   rst_ni,
   wb_if.slave   wb,
   core_if.master core
);
   localparam int CW = cnt_width(MAX_OUTSTANDING);
   state_e                state, state_next;
   logic [CW-1:0]         cnt, cnt_next;
   logic                  run, room, issue, retire, rsp_ack, rsp_err;
   logic [DATA_WIDTH-1:0] rsp_dat;
   assign run        = state == RUN;
   assign room       = cnt < CW'(MAX_OUTSTANDING);
   assign core.req   = run & wb.cyc & wb.stb & room;
   assign wb.stall   = ~(run & core.gnt & room);
   assign core.we    = wb.we;
   assign core.addr  = wb.adr;
   assign core.be    = wb.sel;
   assign core.wdata = wb.dat_m;
   assign issue      = core.req & core.gnt;
   // a response with nothing outstanding is a protocol violation and must not underflow
   assign retire     = core.rvalid & (cnt != '0);
   assign cnt_next   = cnt + CW'(issue) - CW'(retire);
   assign state_next = run ? ((!wb.cyc && cnt_next != '0) ? FLUSH : RUN)
                           : ((cnt_next == '0) ? RUN : FLUSH);
   assign rsp_ack    = run & wb.cyc & core.rvalid & ~core.err;
   assign rsp_err    = run & wb.cyc & core.rvalid & core.err;
   assign rsp_dat    = (rsp_ack | rsp_err) ? core.rdata : '0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end
   if (RSP_REG != 0) begin : g_rsp_reg
      logic                  ack_q, err_q;
      logic [DATA_WIDTH-1:0] dat_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
         end else begin
            ack_q <= rsp_ack;
            err_q <= rsp_err;
            dat_q <= rsp_dat;
         end
      end
      // a cycle dropped while the response sits in the register must not see it
      assign wb.ack   = ack_q & wb.cyc;
      assign wb.err   = err_q & wb.cyc;
      assign wb.dat_s = dat_q;
   end else begin : g_rsp_comb
      assign wb.ack   = rsp_ack;
      assign wb.err   = rsp_err;
      assign wb.dat_s = rsp_dat;
   end
endmodule
